led_mode_ctrl: RTL and testbench

Display-mode controller for the board's 8-LED bank. It converts a raw, already-inverted pushbutton level into debounced press events, and steps through four LED display modes on each press. It generates a slow pattern tick from the 50 MHz clock and drives the LED bank from the selected pattern source. It sits between the top-level key/switch/counter signals and the LED pins, replacing direct LED assignment.

---
 rtl/led_mode_pkg.sv | 23 ++
 rtl/key_debounce.sv | 54 +++++
 rtl/led_mode_ctrl.sv | 138 +++++++++++++
 tb/tb_led_mode_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_mode_pkg.sv
// Shared constants for the LED display-mode controller: mode encoding,
// LED bank width and the bar-graph pattern helper.
package led_mode_pkg;

    localparam int LED_W = 8;
    localparam int POS_W = $clog2(LED_W);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_BAR    = 2'd2,
        MODE_SWITCH = 2'd3
    } led_mode_e;

    // Level 0..LED_W lights that many LEDs from bit 0 upward.
    function automatic logic [LED_W-1:0] bar_pattern(input logic [3:0] level);
        logic [LED_W:0] ones;
        ones = {{LED_W{1'b0}}, 1'b1} << level;
        ones = ones - 1'b1;
        return ones[LED_W-1:0];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce counter, stable
// level and a registered one-cycle pulse on each rising edge of that level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic IN,
    output logic LEVEL,
    output logic PRESS
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d, level_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= IN;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            // Edge detect is registered so the pulse is glitch-free for the mode register.
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign LEVEL = level_q;
    assign PRESS = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED bank mode controller: debounced button steps PASS/SCAN/BAR/SWITCH modes,
// prescaled tick animates the patterns. LED_MODE_CTRL_AUTO_EN adds auto-advance.
module led_mode_ctrl
    import led_mode_pkg::*;
#(
    parameter int TICK_DIV        = 12_500_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int AUTO_TICKS      = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_NEXT,
    input  logic [3:0]       SW,
    input  logic [LED_W-1:0] CNT,
    output logic [LED_W-1:0] LED,
    output logic [1:0]       MODE,
    output logic             TICK
);

    localparam int PW = $clog2(TICK_DIV);

    logic             press, tick, auto_fire, advance;
    logic             btn_level_unused;
    logic [PW-1:0]    presc_q, presc_d;
    led_mode_e        mode_q, mode_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_down_q, dir_down_d;
    logic [3:0]       bar_q, bar_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [LED_W-1:0] scan_led;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .CLK  (CLK),
        .RST  (RST),
        .IN   (BTN_NEXT),
        .LEVEL(btn_level_unused),
        .PRESS(press)
    );

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign advance = press | auto_fire;

`ifdef LED_MODE_CTRL_AUTO_EN
    localparam int AW = $clog2(AUTO_TICKS + 1);

    logic [AW-1:0] auto_cnt_q, auto_cnt_d;

    assign auto_fire = tick && (auto_cnt_q == AW'(AUTO_TICKS - 1));

    always_comb begin
        auto_cnt_d = auto_cnt_q;
        if (advance) begin
            auto_cnt_d = '0;
        end else if (tick) begin
            auto_cnt_d = auto_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    logic unused_auto_ticks;

    assign auto_fire         = 1'b0;
    assign unused_auto_ticks = ^AUTO_TICKS;
`endif

    for (genvar gi = 0; gi < LED_W; gi++) begin : g_scan
        assign scan_led[gi] = (pos_q == POS_W'(gi));
    end

    // A mode change restarts the animation and drops any coincident tick update.
    always_comb begin
        mode_d     = mode_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        pos_d      = pos_q;
        dir_down_d = dir_down_q;
        bar_d      = bar_q;
        if (advance) begin
            mode_d     = led_mode_e'(mode_q + 2'd1);
            presc_d    = '0;
            pos_d      = '0;
            dir_down_d = 1'b0;
            bar_d      = '0;
        end else if (tick) begin
            if (mode_q == MODE_SCAN) begin
                pos_d = dir_down_q ? pos_q - 1'b1 : pos_q + 1'b1;
                if (pos_d == POS_W'(LED_W - 1) || pos_d == '0) begin
                    dir_down_d = ~dir_down_q;
                end
            end
            if (mode_q == MODE_BAR) begin
                bar_d = (bar_q == 4'(LED_W)) ? '0 : bar_q + 1'b1;
            end
        end
    end

    always_comb begin
        led_d = '0;
        case (mode_q)
            MODE_PASS:   led_d = CNT;
            MODE_SCAN:   led_d = scan_led;
            MODE_BAR:    led_d = bar_pattern(bar_q);
            MODE_SWITCH: led_d = {4'b0000, SW};
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q    <= '0;
            mode_q     <= MODE_PASS;
            pos_q      <= '0;
            dir_down_q <= 1'b0;
            bar_q      <= '0;
            led_q      <= '0;
        end else begin
            presc_q    <= presc_d;
            mode_q     <= mode_d;
            pos_q      <= pos_d;
            dir_down_q <= dir_down_d;
            bar_q      <= bar_d;
            led_q      <= led_d;
        end
    end

    assign LED  = led_q;
    assign MODE = mode_q;
    assign TICK = tick;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl: behavioural model compared every cycle,
// directed literal scenarios, then randomized button/reset/input traffic.
module tb_led_mode_ctrl;

    localparam int TD = 4;
    localparam int DC = 8;
    localparam int AT = 3;
`ifdef LED_MODE_CTRL_AUTO_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [3:0] sw  = 4'h0;
    logic [7:0] cnt = 8'h00;
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;

    int checks = 0;
    int errors = 0;

    led_mode_ctrl #(
        .TICK_DIV       (TD),
        .DEBOUNCE_CYCLES(DC),
        .AUTO_TICKS     (AT)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .BTN_NEXT(btn),
        .SW      (sw),
        .CNT     (cnt),
        .LED     (led),
        .MODE    (mode),
        .TICK    (tick)
    );

    always #5 clk = ~clk;

    // Model state: mode, cycles since last mode change, raw-sample history.
    bit         hist [0:DC+1];
    bit         m_level, m_rise1, m_pq, m_valid = 1'b0;
    int         m_mode, m_since;
    logic [7:0] m_led;
    bit         tick_now, auto_now, adv, all_diff;

    function automatic logic [7:0] pat(int md, int since, logic [7:0] c, logic [3:0] s);
        int         n, p;
        logic [7:0] one;
        one = 8'h01;
        n   = since / TD;
        case (md)
            0: return c;
            1: begin
                p = n % 14;
                if (p > 7) p = 14 - p;
                return one << p;
            end
            2: begin
                p = n % 9;
                return (p == 8) ? 8'hFF : (one << p) - 8'h01;
            end
            default: return {4'h0, s};
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_mode  = 0;
            m_since = 0;
            m_led   = 8'h00;
            m_level = 1'b0;
            m_rise1 = 1'b0;
            m_pq    = 1'b0;
            for (int i = 0; i <= DC + 1; i++) hist[i] = 1'b0;
        end else begin
            m_led    = pat(m_mode, m_since, cnt, sw);
            tick_now = (m_since % TD) == TD - 1;
            auto_now = AUTO_ON && tick_now && (m_since / TD + 1 == AT);
            adv      = m_pq || auto_now;
            if (adv) begin
                m_mode  = (m_mode + 1) % 4;
                m_since = 0;
            end else begin
                m_since = m_since + 1;
            end
            for (int i = DC + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0]  = btn;
            // Stable level flips once DC consecutive synchronised samples disagree with it.
            all_diff = 1'b1;
            for (int i = 2; i <= DC + 1; i++) if (hist[i] == m_level) all_diff = 1'b0;
            m_pq    = m_rise1;
            m_rise1 = 1'b0;
            if (all_diff) begin
                m_level = !m_level;
                m_rise1 = m_level;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] model,
                       input logic [31:0] exp);
        cmp(name, act, exp);
        cmp({name, "_model"}, model, exp);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("led", led, m_led);
            cmp("mode", mode, m_mode);
            cmp("tick", tick, (m_since % TD) == TD - 1);
        end
    end

    task automatic do_press();
        int start;
        bit done;
        btn = 1'b0;
        repeat (DC + 4) @(negedge clk);
        start = m_mode;
        done  = 1'b0;
        btn   = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (m_mode != start) done = 1'b1;
        end
        cmp("press_seen", done, 1);
        btn = 1'b0;
    endtask

    logic [7:0] scan_exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] bar_exp [10]  = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                  8'hFF, 8'h00};

    initial begin
        int run;
        rst = 1'b1;
        cnt = 8'hA5;
        repeat (2) @(negedge clk);
        lit("rst_led", led, m_led, 8'h00);
        lit("rst_mode", mode, m_mode, 0);
        lit("rst_tick", tick, (m_since % TD) == TD - 1, 0);
        rst = 1'b0;
        @(negedge clk);
        lit("pass_a5", led, m_led, 8'hA5);

`ifndef LED_MODE_CTRL_AUTO_EN
        btn = 1'b1;
        repeat (5) @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        lit("bounce_mode", mode, m_mode, 0);
        btn = 1'b1;
        repeat (11) @(negedge clk);
        lit("hold_mode_10", mode, m_mode, 0);
        @(negedge clk);
        lit("hold_mode_11", mode, m_mode, 1);
        btn = 1'b0;

        for (int j = 0; j < 16; j++) begin
            repeat ((j == 0) ? 1 : 4) @(negedge clk);
            lit($sformatf("scan_%0d", j), led, m_led, scan_exp[j]);
        end

        do_press();
        for (int j = 0; j < 10; j++) begin
            repeat ((j == 0) ? 1 : 4) @(negedge clk);
            lit($sformatf("bar_%0d", j), led, m_led, bar_exp[j]);
        end

        sw = 4'hA;
        do_press();
        @(negedge clk);
        lit("switch_led", led, m_led, 8'h0A);
        do_press();
        @(negedge clk);
        lit("wrap_mode", mode, m_mode, 0);
        lit("wrap_led", led, m_led, 8'hA5);

        // Re-enter SCAN, then time a press to land on the tick that would leave position 5.
        do_press();
        repeat (12) @(negedge clk);
        btn = 1'b1;
        repeat (11) @(negedge clk);
        lit("coll_pre_mode", mode, m_mode, 1);
        lit("coll_pre_led", led, m_led, 8'h20);
        lit("coll_pre_tick", tick, (m_since % TD) == TD - 1, 1);
        @(negedge clk);
        lit("coll_mode", mode, m_mode, 2);
        @(negedge clk);
        lit("coll_led", led, m_led, 8'h00);
        btn = 1'b0;

        repeat (DC + 4) @(negedge clk);
        btn = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        btn = 1'b0;
        repeat (30) @(negedge clk);
        lit("rst_debounce_mode", mode, m_mode, 0);
`endif

        btn = 1'b0;
        run = 0;
        for (int c = 0; c < 3000; c++) begin
            cnt = 8'($urandom);
            sw  = 4'($urandom);
            if (run == 0) begin
                btn = ~btn;
                run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                  : int'($urandom_range(6, 20));
            end
            run--;
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end

        btn = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef LED_MODE_CTRL_AUTO_EN
        repeat (11) @(negedge clk);
        lit("auto_mode_0", mode, m_mode, 0);
        @(negedge clk);
        lit("auto_mode_1", mode, m_mode, 1);
        repeat (12) @(negedge clk);
        lit("auto_mode_2", mode, m_mode, 2);
`else
        repeat (400) @(negedge clk);
        lit("no_auto_mode", mode, m_mode, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
